// File: rtl/arp_rx_parser.sv
// GMII-side ARP receive parser: strips preamble/SFD, checks the Ethernet/ARP header,
// and pulses the ARP operation for frames addressed to us.
module arp_rx_parser #(
   parameter bit          CHECK_DST_MAC = 1'b1,
   parameter int unsigned MIN_PREAMBLE  = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  i_data,
   input  logic        i_data_vl,
   input  logic [47:0] i_my_mac,
   input  logic [31:0] i_my_ip,
   output logic [1:0]  o_pkt_type,
   output logic [47:0] o_SHA,
   output logic [31:0] o_SPA,
   output logic [7:0]  o_drop_cnt
);

   localparam logic [7:0] MinPre = (MIN_PREAMBLE > 255) ? 8'hFF : 8'(MIN_PREAMBLE);
   localparam logic [5:0] HdrLen = 6'd42;

   typedef enum logic [2:0] {
      StIdle,
      StPreamble,
      StHeader,
      StDrain,
      StReport
   } state_e;

   state_e      state_q, state_d;
   logic [7:0]  pre_cnt_q, pre_cnt_d;
   logic [5:0]  idx_q, idx_d;
   logic        bad_q, bad_d;
   logic        dst_bc_q, dst_bc_d;
   logic        dst_me_q, dst_me_d;
   logic        is_req_q, is_req_d;
   logic [47:0] sha_cap_q, sha_cap_d;
   logic [31:0] spa_cap_q, spa_cap_d;
   logic [47:0] sha_q, sha_d;
   logic [31:0] spa_q, spa_d;
   logic [7:0]  drop_q, drop_d;
   logic [1:0]  pkt_q, pkt_d;

   logic        exp_chk;
   logic [7:0]  exp_byte;
   logic [7:0]  mac_byte;
   logic        frame_ok;

   // Fixed header fields and TPA compare against a per-index expected byte.
   always_comb begin
      exp_chk  = 1'b1;
      exp_byte = 8'h00;
      case (idx_q)
         6'd12:   exp_byte = 8'h08;
         6'd13:   exp_byte = 8'h06;
         6'd14:   exp_byte = 8'h00;
         6'd15:   exp_byte = 8'h01;
         6'd16:   exp_byte = 8'h08;
         6'd17:   exp_byte = 8'h00;
         6'd18:   exp_byte = 8'h06;
         6'd19:   exp_byte = 8'h04;
         6'd20:   exp_byte = 8'h00;
         6'd38:   exp_byte = i_my_ip[31:24];
         6'd39:   exp_byte = i_my_ip[23:16];
         6'd40:   exp_byte = i_my_ip[15:8];
         6'd41:   exp_byte = i_my_ip[7:0];
         default: exp_chk  = 1'b0;
      endcase
   end

   always_comb begin
      case (idx_q[2:0])
         3'd0:    mac_byte = i_my_mac[47:40];
         3'd1:    mac_byte = i_my_mac[39:32];
         3'd2:    mac_byte = i_my_mac[31:24];
         3'd3:    mac_byte = i_my_mac[23:16];
         3'd4:    mac_byte = i_my_mac[15:8];
         default: mac_byte = i_my_mac[7:0];
      endcase
   end

   assign frame_ok = (idx_q == HdrLen) && !bad_q;

   always_comb begin
      state_d   = state_q;
      pre_cnt_d = pre_cnt_q;
      idx_d     = idx_q;
      bad_d     = bad_q;
      dst_bc_d  = dst_bc_q;
      dst_me_d  = dst_me_q;
      is_req_d  = is_req_q;
      sha_cap_d = sha_cap_q;
      spa_cap_d = spa_cap_q;
      sha_d     = sha_q;
      spa_d     = spa_q;
      drop_d    = drop_q;
      pkt_d     = 2'b00;

      case (state_q)
         StIdle: begin
            if (i_data_vl) begin
               if (i_data == 8'h55) begin
                  state_d   = StPreamble;
                  pre_cnt_d = 8'd1;
               end else begin
                  state_d = StDrain;
               end
            end
         end

         StPreamble: begin
            if (!i_data_vl) begin
               state_d = StIdle;
            end else if (i_data == 8'h55) begin
               if (pre_cnt_q != 8'hFF) pre_cnt_d = pre_cnt_q + 8'd1;
            end else if ((i_data == 8'hD5) && (pre_cnt_q >= MinPre)) begin
               state_d  = StHeader;
               idx_d    = 6'd0;
               bad_d    = 1'b0;
               dst_bc_d = 1'b1;
               dst_me_d = 1'b1;
               is_req_d = 1'b0;
            end else begin
               state_d = StDrain;
            end
         end

         StHeader: begin
            if (i_data_vl) begin
               if (idx_q < HdrLen) begin
                  idx_d = idx_q + 6'd1;
                  if (exp_chk && (i_data != exp_byte)) bad_d = 1'b1;
                  if (idx_q <= 6'd5) begin
                     if (i_data != 8'hFF) dst_bc_d = 1'b0;
                     if (i_data != mac_byte) dst_me_d = 1'b0;
                     if ((idx_q == 6'd5) && CHECK_DST_MAC && !dst_bc_d && !dst_me_d) begin
                        bad_d = 1'b1;
                     end
                  end else if (idx_q == 6'd21) begin
                     is_req_d = (i_data == 8'h01);
                     if ((i_data != 8'h01) && (i_data != 8'h02)) bad_d = 1'b1;
                  end else if ((idx_q >= 6'd22) && (idx_q <= 6'd27)) begin
                     sha_cap_d = {sha_cap_q[39:0], i_data};
                  end else if ((idx_q >= 6'd28) && (idx_q <= 6'd31)) begin
                     spa_cap_d = {spa_cap_q[23:0], i_data};
                  end
               end
            end else begin
               // Result is registered so it appears in the REPORT cycle itself.
               state_d = StReport;
               if (frame_ok) begin
                  pkt_d = is_req_q ? 2'b01 : 2'b10;
                  sha_d = sha_cap_q;
                  spa_d = spa_cap_q;
               end else begin
                  drop_d = drop_q + 8'd1;
               end
            end
         end

         StDrain: begin
            if (!i_data_vl) state_d = StIdle;
         end

         StReport: begin
            state_d = i_data_vl ? StDrain : StIdle;
         end

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         pre_cnt_q <= 8'd0;
         idx_q     <= 6'd0;
         bad_q     <= 1'b0;
         dst_bc_q  <= 1'b0;
         dst_me_q  <= 1'b0;
         is_req_q  <= 1'b0;
         sha_cap_q <= 48'd0;
         spa_cap_q <= 32'd0;
         sha_q     <= 48'd0;
         spa_q     <= 32'd0;
         drop_q    <= 8'd0;
         pkt_q     <= 2'b00;
      end else begin
         state_q   <= state_d;
         pre_cnt_q <= pre_cnt_d;
         idx_q     <= idx_d;
         bad_q     <= bad_d;
         dst_bc_q  <= dst_bc_d;
         dst_me_q  <= dst_me_d;
         is_req_q  <= is_req_d;
         sha_cap_q <= sha_cap_d;
         spa_cap_q <= spa_cap_d;
         sha_q     <= sha_d;
         spa_q     <= spa_d;
         drop_q    <= drop_d;
         pkt_q     <= pkt_d;
      end
   end

   assign o_pkt_type = pkt_q;
   assign o_SHA      = sha_q;
   assign o_SPA      = spa_q;
   assign o_drop_cnt = drop_q;

endmodule

// File: tb/tb_arp_rx_parser.sv
// Scoreboard bench for arp_rx_parser: each frame pushes its expected result, which is
// popped and compared in the REPORT cycle.
module tb_arp_rx_parser;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  i_data;
   logic        i_data_vl;
   logic [47:0] i_my_mac;
   logic [31:0] i_my_ip;
   logic [1:0]  o_pkt_type;
   logic [47:0] o_SHA;
   logic [31:0] o_SPA;
   logic [7:0]  o_drop_cnt;

   arp_rx_parser dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_data     (i_data),
      .i_data_vl  (i_data_vl),
      .i_my_mac   (i_my_mac),
      .i_my_ip    (i_my_ip),
      .o_pkt_type (o_pkt_type),
      .o_SHA      (o_SHA),
      .o_SPA      (o_SPA),
      .o_drop_cnt (o_drop_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  pkt;
      logic [47:0] sha;
      logic [31:0] spa;
      logic [7:0]  drop;
   } exp_t;

   localparam logic [47:0] MyMac = 48'h0A1B2C3D4E5F;
   localparam logic [31:0] MyIp  = 32'hC0A80102;
   localparam logic [47:0] Bcast = 48'hFFFFFFFFFFFF;

   int          checks = 0;
   int          failures = 0;
   int          exp_pulses = 0;
   int          seen_pulses = 0;
   exp_t        exp_q[$];
   logic [7:0]  frm[$];
   logic [47:0] m_sha;
   logic [31:0] m_spa;
   logic [7:0]  m_drop;
   logic [15:0] f_oper;
   logic [47:0] f_sha;
   logic [31:0] f_spa;

   always @(negedge clk) if (o_pkt_type !== 2'b00) seen_pulses++;

   task automatic push_field(input logic [47:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) frm.push_back(v[8*i +: 8]);
   endtask

   task automatic build(input logic [47:0] dst, input logic [15:0] etype,
                        input logic [15:0] oper, input logic [47:0] sha,
                        input logic [31:0] spa, input logic [31:0] tpa);
      frm.delete();
      for (int i = 0; i < 7; i++) frm.push_back(8'h55);
      frm.push_back(8'hD5);
      push_field(dst, 6);
      push_field(48'h020000000001, 6);
      push_field({32'd0, etype}, 2);
      push_field(48'h0001, 2);
      push_field(48'h0800, 2);
      push_field(48'h06, 1);
      push_field(48'h04, 1);
      push_field({32'd0, oper}, 2);
      push_field(sha, 6);
      push_field({16'd0, spa}, 4);
      push_field(48'd0, 6);
      push_field({16'd0, tpa}, 4);
      for (int i = 0; i < 18; i++) frm.push_back(8'h00);
      push_field(48'h12345678, 4);
      f_oper = oper;
      f_sha  = sha;
      f_spa  = spa;
   endtask

   // Drives frm[start..stop-1] one byte per clock, then drops dv.
   task automatic drive(input int start, input int stop);
      for (int i = start; i < stop; i++) begin
         @(posedge clk);
         #1;
         i_data    = frm[i];
         i_data_vl = 1'b1;
      end
      @(posedge clk);
      #1;
      i_data_vl = 1'b0;
      i_data    = 8'h00;
   endtask

   task automatic send(input logic ok, input int stop);
      exp_t e;
      if (ok) begin
         m_sha = f_sha;
         m_spa = f_spa;
         e.pkt = (f_oper == 16'd1) ? 2'b01 : 2'b10;
         exp_pulses++;
      end else begin
         m_drop = m_drop + 8'd1;
         e.pkt  = 2'b00;
      end
      e.sha  = m_sha;
      e.spa  = m_spa;
      e.drop = m_drop;
      exp_q.push_back(e);
      drive(0, stop);
   endtask

   task automatic test_reset;
      rst_n     = 1'b0;
      i_data    = 8'h00;
      i_data_vl = 1'b0;
      i_my_mac  = MyMac;
      i_my_ip   = MyIp;
      m_sha     = '0;
      m_spa     = '0;
      m_drop    = '0;
      #12;
      checks++;
      if (o_pkt_type !== 2'b00) begin
         failures++; $display("FAIL reset_pkt: got %h want 0", o_pkt_type);
      end
      checks++;
      if (o_SHA !== 48'd0) begin failures++; $display("FAIL reset_sha: got %h want 0", o_SHA); end
      checks++;
      if (o_SPA !== 32'd0) begin failures++; $display("FAIL reset_spa: got %h want 0", o_SPA); end
      checks++;
      if (o_drop_cnt !== 8'd0) begin
         failures++; $display("FAIL reset_drop: got %h want 0", o_drop_cnt);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   // Accepted, rejected and truncated frames; each result checked in its REPORT cycle.
   task automatic test_frames;
      exp_t e;
      for (int t = 0; t < 6; t++) begin
         case (t)
            0: begin build(Bcast, 16'h0806, 16'd1, 48'h001122334455, 32'hC0A80101, MyIp); send(1'b1, frm.size()); end
            1: begin build(MyMac, 16'h0806, 16'd2, 48'h66778899AABB, 32'hC0A80105, MyIp); send(1'b1, frm.size()); end
            2: begin build(Bcast, 16'h0806, 16'd1, 48'h001122334455, 32'hC0A80101, 32'hC0A80199); send(1'b0, frm.size()); end
            3: begin build(Bcast, 16'h0806, 16'd1, 48'h001122334455, 32'hC0A80101, MyIp); send(1'b0, 38); end
            4: begin build(Bcast, 16'h0800, 16'd1, 48'h001122334455, 32'hC0A80101, MyIp); send(1'b0, frm.size()); end
            default: begin build(48'h0A1B2C3D4E00, 16'h0806, 16'd1, 48'h001122334455, 32'hC0A80101, MyIp); send(1'b0, frm.size()); end
         endcase
         @(posedge clk);
         @(negedge clk);
         e = exp_q.pop_front();
         checks++;
         if ({o_pkt_type, o_SHA, o_SPA, o_drop_cnt} !== {e.pkt, e.sha, e.spa, e.drop}) begin
            failures++;
            $display("FAIL frame%0d: got pkt=%h sha=%h spa=%h drop=%0d want pkt=%h sha=%h spa=%h drop=%0d",
                     t, o_pkt_type, o_SHA, o_SPA, o_drop_cnt, e.pkt, e.sha, e.spa, e.drop);
         end
         @(negedge clk);
         checks++;
         if (o_pkt_type !== 2'b00) begin
            failures++; $display("FAIL frame%0d_width: got %h want 0 after pulse", t, o_pkt_type);
         end
      end
   endtask

   // Bad preamble drains silently; a good frame after a one-cycle gap is accepted.
   task automatic test_bad_preamble;
      exp_t e;
      build(Bcast, 16'h0806, 16'd1, 48'hA0A1A2A3A4A5, 32'hC0A80177, MyIp);
      frm[2] = 8'hAA;
      drive(0, frm.size());
      build(Bcast, 16'h0806, 16'd2, 48'hB0B1B2B3B4B5, 32'hC0A80178, MyIp);
      send(1'b1, frm.size());
      @(posedge clk);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({o_pkt_type, o_SHA, o_SPA, o_drop_cnt} !== {e.pkt, e.sha, e.spa, e.drop}) begin
         failures++;
         $display("FAIL after_bad_preamble: got pkt=%h sha=%h spa=%h drop=%0d want pkt=%h sha=%h spa=%h drop=%0d",
                  o_pkt_type, o_SHA, o_SPA, o_drop_cnt, e.pkt, e.sha, e.spa, e.drop);
      end
   endtask

   // dv rises during REPORT: that frame is drained, then the next one parses normally.
   task automatic test_back_to_back;
      exp_t e;
      build(Bcast, 16'h0806, 16'd1, 48'hC0C1C2C3C4C5, 32'hC0A80111, MyIp);
      send(1'b1, frm.size());
      build(Bcast, 16'h0806, 16'd2, 48'hD0D1D2D3D4D5, 32'hC0A80112, MyIp);
      @(posedge clk);
      #1;
      i_data    = frm[0];
      i_data_vl = 1'b1;
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({o_pkt_type, o_SHA, o_SPA, o_drop_cnt} !== {e.pkt, e.sha, e.spa, e.drop}) begin
         failures++;
         $display("FAIL b2b_first: got pkt=%h sha=%h spa=%h drop=%0d want pkt=%h sha=%h spa=%h drop=%0d",
                  o_pkt_type, o_SHA, o_SPA, o_drop_cnt, e.pkt, e.sha, e.spa, e.drop);
      end
      drive(1, frm.size());
      repeat (3) @(negedge clk);
      checks++;
      if ({o_SHA, o_SPA, o_drop_cnt} !== {m_sha, m_spa, m_drop}) begin
         failures++;
         $display("FAIL b2b_drained: got sha=%h spa=%h drop=%0d want sha=%h spa=%h drop=%0d",
                  o_SHA, o_SPA, o_drop_cnt, m_sha, m_spa, m_drop);
      end
   endtask

   // Reset in the middle of a frame: outputs clear at once, the tail drains.
   task automatic test_reset_mid_frame;
      exp_t e;
      build(Bcast, 16'h0806, 16'd1, 48'h001122334455, 32'hC0A80101, MyIp);
      for (int i = 0; i < 34; i++) begin
         @(posedge clk);
         #1;
         i_data    = frm[i];
         i_data_vl = 1'b1;
      end
      #2;
      rst_n  = 1'b0;
      m_sha  = '0;
      m_spa  = '0;
      m_drop = '0;
      #1;
      checks++;
      if ({o_pkt_type, o_SHA, o_SPA, o_drop_cnt} !== 90'd0) begin
         failures++;
         $display("FAIL mid_reset: got pkt=%h sha=%h spa=%h drop=%0d want all 0",
                  o_pkt_type, o_SHA, o_SPA, o_drop_cnt);
      end
      @(posedge clk);
      #1;
      rst_n  = 1'b1;
      i_data = frm[34];
      drive(35, frm.size());
      repeat (3) @(negedge clk);
      checks++;
      if ({o_SHA, o_SPA, o_drop_cnt} !== 88'd0) begin
         failures++;
         $display("FAIL mid_reset_tail: got sha=%h spa=%h drop=%0d want 0",
                  o_SHA, o_SPA, o_drop_cnt);
      end
      send(1'b1, frm.size());
      @(posedge clk);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({o_pkt_type, o_SHA, o_SPA, o_drop_cnt} !== {e.pkt, e.sha, e.spa, e.drop}) begin
         failures++;
         $display("FAIL mid_reset_next: got pkt=%h sha=%h spa=%h drop=%0d want pkt=%h sha=%h spa=%h drop=%0d",
                  o_pkt_type, o_SHA, o_SPA, o_drop_cnt, e.pkt, e.sha, e.spa, e.drop);
      end
   endtask

   // 256 short rejected frames bring the drop counter back to where it started.
   task automatic test_drop_wrap;
      exp_t       e;
      logic [7:0] start;
      start = m_drop;
      build(Bcast, 16'h0806, 16'd1, 48'h001122334455, 32'hC0A80101, MyIp);
      for (int n = 0; n < 256; n++) begin
         send(1'b0, 10);
         @(posedge clk);
         @(negedge clk);
         e = exp_q.pop_front();
         checks++;
         if ({o_pkt_type, o_drop_cnt} !== {e.pkt, e.drop}) begin
            failures++;
            $display("FAIL wrap%0d: got pkt=%h drop=%0d want pkt=%h drop=%0d",
                     n, o_pkt_type, o_drop_cnt, e.pkt, e.drop);
         end
      end
      checks++;
      if (o_drop_cnt !== start) begin
         failures++; $display("FAIL wrap_total: got %0d want %0d", o_drop_cnt, start);
      end
   endtask

   task automatic test_pulse_count;
      repeat (3) @(negedge clk);
      checks++;
      if (seen_pulses !== exp_pulses) begin
         failures++; $display("FAIL pulse_count: got %0d want %0d", seen_pulses, exp_pulses);
      end
      checks++;
      if (exp_q.size() !== 0) begin
         failures++; $display("FAIL scoreboard_left: got %0d want 0", exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_frames();
      test_bad_preamble();
      test_back_to_back();
      test_reset_mid_frame();
      test_drop_wrap();
      test_pulse_count();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/arp_rx_parser.md
ARP_RX_PARSER -- requirements
Module: arp_rx_parser

Interface
REQ-001 SHALL have parameter CHECK_DST_MAC, default 1: 1 = accept only broadcast or i_my_mac destination; 0 = accept any destination.
REQ-002 SHALL have parameter MIN_PREAMBLE, default 1: minimum count of 0x55 bytes required before SFD 0xD5.
REQ-003 SHALL have port clk  input  1  single clock, receive byte clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_data  input  8  GMII receive byte.
REQ-006 SHALL have port i_data_vl  input  1  receive data valid; high for the whole frame including preamble.
REQ-007 SHALL have port i_my_mac  input  48  local MAC, quasi-static.
REQ-008 SHALL have port i_my_ip  input  32  local IPv4, quasi-static.
REQ-009 SHALL have port o_pkt_type  output  2  one-cycle result pulse: 01 ARP request for us, 10 ARP reply for us, 00 none.
REQ-010 SHALL have port o_SHA  output  48  sender MAC of the last accepted frame.
REQ-011 SHALL have port o_SPA  output  32  sender IP of the last accepted frame.
REQ-012 SHALL have port o_drop_cnt  output  8  count of rejected frames, wraps 255->0.

Function
REQ-013 SHALL implement states IDLE, PREAMBLE, HEADER, DRAIN, REPORT.
REQ-014 IDLE: on i_data_vl=1 with i_data=0x55 SHALL go to PREAMBLE with preamble count 1; with any other byte SHALL go to DRAIN without counting a drop.
REQ-015 PREAMBLE: each 0x55 SHALL increment the saturating preamble count; on 0xD5 with count >= MIN_PREAMBLE SHALL go to HEADER with byte index 0; any other byte or a short preamble SHALL go to DRAIN without counting a drop.
REQ-016 HEADER: SHALL capture byte index 0..41 in order: dst MAC 0-5, src MAC 6-11, ethertype 12-13, htype 14-15, ptype 16-17, hlen 18, plen 19, oper 20-21, SHA 22-27, SPA 28-31, THA 32-37, TPA 38-41; MSB first; the 6-bit index SHALL saturate at 42.
REQ-017 Checks: ethertype=0x0806, htype=0x0001, ptype=0x0800, hlen=6, plen=4, oper in {1,2}, TPA=i_my_ip, and, if CHECK_DST_MAC=1, dst MAC = FF:FF:FF:FF:FF:FF or i_my_mac; any failure SHALL set a sticky bad flag for the frame.
REQ-018 Bytes after index 41 (padding, FCS) SHALL be ignored; FCS SHALL NOT be checked.
REQ-019 HEADER on i_data_vl=0: SHALL go to REPORT; the frame is valid only if index = 42 and the bad flag is clear.
REQ-020 REPORT (one cycle): valid frame SHALL drive o_pkt_type = 01 (oper 1) or 10 (oper 2) and load o_SHA/o_SPA in the same cycle; invalid frame SHALL drive 00 and increment o_drop_cnt; SHALL return to IDLE next cycle.
REQ-021 Latency: the o_pkt_type pulse SHALL occur exactly 1 cycle after the first clock with i_data_vl=0 that ends the frame.
REQ-022 DRAIN SHALL wait for i_data_vl=0, then go to IDLE, with no pulse and no drop count.
REQ-023 If i_data_vl rises in the REPORT cycle, that byte SHALL be ignored and the frame SHALL be consumed via DRAIN.
REQ-024 o_pkt_type SHALL be 00 in every cycle except REPORT; o_SHA/o_SPA SHALL hold between accepted frames and SHALL NOT be changed by rejected frames.

Reset
REQ-025 rst_n=0 SHALL immediately force state IDLE and set o_pkt_type=00, o_SHA=0, o_SPA=0, o_drop_cnt=0, with counters and flags cleared.
REQ-026 Reset asserted mid-frame SHALL abort with no pulse; after release, the rest of that frame (dv still high) SHALL be consumed via DRAIN when its first byte is not 0x55.

Verification
REQ-027 7x55, D5, broadcast ARP request oper=1, TPA=i_my_ip=C0A80102, SHA=001122334455, SPA=C0A80101, 18 pad + 4 FCS -> o_pkt_type=01 for one cycle, 1 cycle after dv falls; o_SHA=001122334455; o_SPA=C0A80101.
REQ-028 Same frame with oper=2 and dst=i_my_mac -> o_pkt_type=10; with TPA=C0A80199 -> 00, o_drop_cnt+1, o_SHA unchanged.
REQ-029 Frame truncated at byte index 30 (dv drops) -> no pulse, o_drop_cnt+1.
REQ-030 ethertype 0x0800 frame -> o_drop_cnt+1; 256 rejected frames -> o_drop_cnt wraps to 0.
REQ-031 Preamble 55 55 AA... -> DRAIN, no pulse, no drop; the next good frame after a one-cycle dv gap is accepted.
REQ-032 rst_n pulsed at byte index 25 of a good frame -> all outputs 0, no pulse for that frame, next frame parsed normally.
